// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: prescaled one-second tick, mm:ss BCD digit chain,
// start/pause/lap/clear state machine and registered display selection.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] disp_sec_u,
  output logic [3:0] disp_sec_t,
  output logic [3:0] disp_min_u,
  output logic [3:0] disp_min_t,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);

  localparam int PW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_LAP    = 2'd2;
  localparam logic [1:0] ST_PAUSED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_u_q, sec_u_d;
  logic [3:0]    sec_t_q, sec_t_d;
  logic [3:0]    min_u_q, min_u_d;
  logic [3:0]    min_t_q, min_t_d;
  logic [15:0]   snap_q, snap_d;
  logic          roll_q, roll_d;

  logic counting;
  logic tick;
  logic carry_su, carry_st, carry_mu;

  // BCD digit increment that wraps to zero past its top value
  function automatic logic [3:0] bcd_inc(input logic [3:0] v, input logic [3:0] top);
    bcd_inc = (v >= top) ? 4'd0 : v + 4'd1;
  endfunction

  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick     = counting && (presc_q == PRESC_MAX);
  assign carry_su = (sec_u_q == 4'd9);
  assign carry_st = carry_su && (sec_t_q == 4'd5);
  assign carry_mu = carry_st && (min_u_q == 4'd9);

  // Next-state: prescaler, digit chain, snapshot and button-driven FSM
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_u_d = sec_u_q;
    sec_t_d = sec_t_q;
    min_u_d = min_u_q;
    min_t_d = min_t_q;
    snap_d  = snap_q;
    roll_d  = 1'b0;

    if (counting) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      sec_u_d = bcd_inc(sec_u_q, 4'd9);
      if (carry_su) sec_t_d = bcd_inc(sec_t_q, 4'd5);
      if (carry_st) min_u_d = bcd_inc(min_u_q, 4'd9);
      if (carry_mu) min_t_d = bcd_inc(min_t_q, 4'd5);
      roll_d = carry_mu && (min_t_q == 4'd5);
    end

    // start_stop outranks lap, so a lap arriving with it is dropped
    case (state_q)
      ST_IDLE: begin
        if (start_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_stop) begin
          state_d = ST_PAUSED;
        end else if (lap) begin
          state_d = ST_LAP;
          snap_d  = {min_t_q, min_u_q, sec_t_q, sec_u_q};
        end
      end
      ST_LAP: begin
        if (start_stop)  state_d = ST_PAUSED;
        else if (lap)    state_d = ST_RUN;
      end
      ST_PAUSED: begin
        if (start_stop) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // clear wins over everything, including a tick in flight
    if (clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      sec_u_d = 4'd0;
      sec_t_d = 4'd0;
      min_u_d = 4'd0;
      min_t_d = 4'd0;
      snap_d  = 16'd0;
      roll_d  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      sec_u_q <= 4'd0;
      sec_t_q <= 4'd0;
      min_u_q <= 4'd0;
      min_t_q <= 4'd0;
      snap_q  <= 16'd0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_u_q <= sec_u_d;
      sec_t_q <= sec_t_d;
      min_u_q <= min_u_d;
      min_t_q <= min_t_d;
      snap_q  <= snap_d;
      roll_q  <= roll_d;
    end
  end

  // Display shows the frozen snapshot only while in LAP
  always_comb begin
    if (state_q == ST_LAP) begin
      {disp_min_t, disp_min_u, disp_sec_t, disp_sec_u} = snap_q;
    end else begin
      {disp_min_t, disp_min_u, disp_sec_t, disp_sec_u} = {min_t_q, min_u_q, sec_t_q, sec_u_q};
    end
  end

  assign running    = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign lap_active = (state_q == ST_LAP);
  assign rollover   = roll_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4; expectations are queued
// by the stimulus and checked by an independent monitor on the falling edge.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] disp_sec_u, disp_sec_t, disp_min_u, disp_min_t;
  logic       running, lap_active, rollover;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [18:0] v;   // {mm:ss BCD, running, lap_active, rollover}
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [18:0] act;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .disp_sec_u (disp_sec_u),
    .disp_sec_t (disp_sec_t),
    .disp_min_u (disp_min_u),
    .disp_min_t (disp_min_t),
    .running    (running),
    .lap_active (lap_active),
    .rollover   (rollover)
  );

  always #5 clk = ~clk;

  // Monitor: drain every queued expectation against the outputs mid-cycle
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      act = {disp_min_t, disp_min_u, disp_sec_t, disp_sec_u, running, lap_active, rollover};
      n_tests++;
      if (act !== cur.v) begin
        n_fail++;
        $display("FAIL %s: got mmss=%h run/lap/roll=%b, want mmss=%h run/lap/roll=%b",
                 cur.name, act[18:3], act[2:0], cur.v[18:3], cur.v[2:0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ss, input logic cl, input logic lp);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    step(1);
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [15:0] mmss,
                            input logic r, input logic l, input logic o);
    exp_t e;
    e.name = nm;
    e.v    = {mmss, r, l, o};
    sb_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    step(3);
    reset = 1'b0;
    expect_out("reset", 16'h0000, 0, 0, 0);

    // Start and count; one tick every 4 cycles
    pulse(1, 0, 0);
    expect_out("run_start", 16'h0000, 1, 0, 0);
    step(3);  expect_out("pre_first_tick", 16'h0000, 1, 0, 0);
    step(1);  expect_out("first_tick", 16'h0001, 1, 0, 0);
    step(32); expect_out("sec_09", 16'h0009, 1, 0, 0);
    step(4);  expect_out("sec_carry_10", 16'h0010, 1, 0, 0);
    step(196); expect_out("sec_59", 16'h0059, 1, 0, 0);
    step(4);  expect_out("min_carry_0100", 16'h0100, 1, 0, 0);
    step(2156); expect_out("min_09_59", 16'h0959, 1, 0, 0);
    step(4);  expect_out("min_carry_1000", 16'h1000, 1, 0, 0);
    step(11996); expect_out("at_59_59", 16'h5959, 1, 0, 0);
    step(3);  expect_out("hold_59_59", 16'h5959, 1, 0, 0);
    step(1);  expect_out("rollover", 16'h0000, 1, 0, 1);
    step(1);  expect_out("rollover_one_cycle", 16'h0000, 1, 0, 0);
    step(3);  expect_out("after_roll_tick", 16'h0001, 1, 0, 0);

    // Pause with a partial second and resume it
    step(10); expect_out("at_03_p2", 16'h0003, 1, 0, 0);
    pulse(1, 0, 0); expect_out("paused", 16'h0003, 0, 0, 0);
    step(20); expect_out("paused_hold", 16'h0003, 0, 0, 0);
    pulse(1, 0, 0); expect_out("resumed", 16'h0003, 1, 0, 0);
    step(1);  expect_out("resume_tick", 16'h0004, 1, 0, 0);

    // Lap freeze and release
    step(4);  expect_out("at_05", 16'h0005, 1, 0, 0);
    pulse(0, 0, 1); expect_out("lap_enter", 16'h0005, 1, 1, 0);
    step(12); expect_out("lap_frozen", 16'h0005, 1, 1, 0);
    pulse(0, 0, 1); expect_out("lap_release", 16'h0008, 1, 0, 0);

    // Clear with every button, in LAP with a tick pending
    pulse(0, 0, 1); expect_out("lap_again", 16'h0008, 1, 1, 0);
    pulse(1, 1, 1); expect_out("clear_in_lap", 16'h0000, 0, 0, 0);
    step(5);  expect_out("idle_hold", 16'h0000, 0, 0, 0);
    pulse(0, 0, 1); expect_out("idle_lap_ignored", 16'h0000, 0, 0, 0);

    // Reset mid-RUN
    pulse(1, 0, 0);
    step(9);  expect_out("run_before_reset", 16'h0002, 1, 0, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_out("reset_mid_run", 16'h0000, 0, 0, 0);

    // start_stop beats lap; lap ignored in PAUSED
    pulse(1, 0, 0);
    step(5);  expect_out("run_01", 16'h0001, 1, 0, 0);
    pulse(1, 0, 1); expect_out("ss_beats_lap", 16'h0001, 0, 0, 0);
    pulse(0, 0, 1); expect_out("paused_lap_ignored", 16'h0001, 0, 0, 0);

    // LAP -> PAUSED shows live digits again
    pulse(1, 0, 0); expect_out("resume_p2", 16'h0001, 1, 0, 0);
    pulse(0, 0, 1); expect_out("lap_at_01", 16'h0001, 1, 1, 0);
    step(1);  expect_out("lap_live_moves", 16'h0001, 1, 1, 0);
    step(4);  expect_out("lap_still_frozen", 16'h0001, 1, 1, 0);
    pulse(1, 0, 0); expect_out("lap_to_paused_live", 16'h0003, 0, 0, 0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller for the mm:ss stopwatch datapath. It generates the one-second enable from a prescaler and sequences a four-digit BCD chain: seconds units 0-9, seconds tens 0-5, minutes units 0-9 and minutes tens 0-5. It runs a start/pause/lap/clear state machine driven by debounced single-cycle button pulses, and presents display digits to the 7-segment multiplexer.

Parameters:
TICK_DIV, 11, clock cycles per counting tick (one second in the real build); legal range is 2 or more.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start_stop  input  1  single-cycle pulse that toggles between running and paused
clear  input  1  single-cycle pulse that zeroes the stopwatch and returns to IDLE
lap  input  1  single-cycle pulse that freezes or releases the display while counting continues
disp_sec_u  output  4  displayed seconds units, BCD 0-9
disp_sec_t  output  4  displayed seconds tens, BCD 0-5
disp_min_u  output  4  displayed minutes units, BCD 0-9
disp_min_t  output  4  displayed minutes tens, BCD 0-5
running  output  1  high in RUN or LAP
lap_active  output  1  high in LAP
rollover  output  1  one-cycle pulse on the 59:59 -> 00:00 wrap

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state IDLE; prescaler, live digits and snapshot all 0; every output 0.
- States:
  - IDLE: start_stop -> RUN. lap is ignored.
  - RUN: start_stop -> PAUSED. lap -> LAP, and the snapshot latches the live digits on the same edge.
  - LAP: start_stop -> PAUSED, and the display returns to live digits. lap -> RUN, releasing the freeze.
  - PAUSED: start_stop -> RUN. lap is ignored.
  - clear: from any state, next cycle goes to IDLE with prescaler, digits and snapshot at 0.
- Priority on the same cycle: clear first, then start_stop, then lap. A lap pulse arriving with start_stop is dropped.
- Prescaler:
  - Increments every cycle in RUN or LAP.
  - At TICK_DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
  - In PAUSED it holds its value, so resume continues the partial second.
  - In IDLE it is 0.
- Digit chain, advanced only on tick:
  - sec_u increments; 9 wraps to 0 with carry.
  - sec_t increments on carry; 5 wraps to 0 with carry.
  - min_u increments on carry; 9 wraps to 0 with carry.
  - min_t increments on carry; 5 wraps to 0.
  - Every register update is on the clk edge ending the tick cycle and is visible the next cycle.
- Rollover: on a tick with the live value at 59:59, all digits go to 0 and rollover is high for exactly one cycle, aligned with digits reading 00:00. Counting continues in RUN/LAP without stopping.
- Display:
  - disp_* equals the live digits in IDLE, RUN and PAUSED.
  - disp_* equals the snapshot in LAP. Live digits keep advancing underneath.
- Transition timing: a tick coinciding with a start_stop pause is still applied. A start_stop in RUN/LAP stops counting from the next cycle.
- Register widths:
  - Prescaler is $clog2(TICK_DIV) bits, minimum 1.
  - Each digit is 4 bits. No value outside its BCD range is ever produced.
- Outputs: all registered, no combinational input-to-output path. running and lap_active follow the state register.
- Mid-operation: reset or clear during any state, including LAP with a pending tick, yields the full reset values on the next cycle. The tick is discarded.

Test Plan:
(All scenarios use TICK_DIV=4.)
- Reset, then start_stop pulse, then run 40 cycles -> disp reads 00:10, running=1; digits change every 4 cycles.
- Preload by running to 00:09, then 4 more cycles -> 00:10 (sec_u carry into sec_t). Continue to 00:59 plus one tick -> 01:00.
- Run to 59:59, then one tick -> 00:00 with rollover high for exactly 1 cycle; running stays 1 and the next tick gives 00:01.
- At 00:03 with prescaler=2, pulse start_stop, wait 20 cycles, then pulse start_stop -> display holds 00:03 while paused; 00:04 appears 2 cycles after resume.
- At 00:05 pulse lap, run 12 cycles -> disp stays 00:05 with lap_active=1. Pulse lap -> disp jumps to 00:08 next cycle.
- In LAP, pulse clear together with start_stop and lap -> next cycle IDLE, all disp 0, running=0, lap_active=0. Also assert reset mid-RUN -> identical result.
